// File: rtl/eggtimer_pkg.sv
// Key-FSM state encoding shared by the key conditioner and any later key-consuming logic.
package eggtimer_pkg;

  localparam logic [2:0] KS_IDLE         = 3'd0;
  localparam logic [2:0] KS_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] KS_DOWN         = 3'd2;
  localparam logic [2:0] KS_HELD         = 3'd3;
  localparam logic [2:0] KS_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE         = KS_IDLE,
    ST_PRESS_WAIT   = KS_PRESS_WAIT,
    ST_DOWN         = KS_DOWN,
    ST_HELD         = KS_HELD,
    ST_RELEASE_WAIT = KS_RELEASE_WAIT
  } key_state_t;

  // A key counts as accepted-down until its release has been debounced.
  function automatic logic is_down(key_state_t s);
    return (s == ST_DOWN) || (s == ST_HELD) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, tick-driven debounce FSM, hold-to-repeat, registered pulses.
module key_channel
  import eggtimer_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_TICKS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TICKS);

  logic [1:0]    sync_q;
  logic          lvl;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;

  assign lvl      = sync_q[1];
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
  assign rep_inc  = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: if (lvl) begin
          if (DEBOUNCE_TICKS == 1) begin
            state_d = ST_DOWN;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!lvl) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DOWN, ST_HELD: begin
          if (!lvl) begin
            // A single-tick debounce accepts the release on the first low tick.
            if (DEBOUNCE_TICKS == 1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              rel_d   = 1'b1;
            end else begin
              state_d = ST_RELEASE_WAIT;
              cnt_d   = CW'(1);
            end
          end else if (state_q == ST_DOWN) begin
            hold_d = hold_inc;
            if (REPEAT_EN && hold_inc == HOLD_MAX) begin
              state_d = ST_HELD;
              rep_d   = '0;
              rpt_d   = 1'b1;
            end
          end else if (rep_inc == REP_MAX) begin
            rep_d = '0;
            rpt_d = 1'b1;
          end else begin
            rep_d = rep_inc;
          end
        end
        ST_RELEASE_WAIT: begin
          if (lvl) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            hold_d  = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~key_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign pressed       = is_down(state_q);
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces NUM_KEYS active-low buttons against one shared tick prescaler.
module key_conditioner #(
  parameter int                  NUM_KEYS       = 3,
  parameter int                  TICK_DIV       = 50000,
  parameter int                  DEBOUNCE_TICKS = 20,
  parameter int                  HOLD_TICKS     = 500,
  parameter int                  REPEAT_TICKS   = 100,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK    = {NUM_KEYS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_q, div_d;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS),
      .REPEAT_EN     (REPEAT_MASK[g])
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .key_n        (keys_n[g]),
      .pressed      (pressed[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboarded bench: tests push expected pulse events, a negedge monitor pops and compares them.
module tb_key_conditioner;

  localparam int KP = 0, KR = 1, KT = 2;  // press, release, repeat

  typedef struct {
    int kind;
    int key;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] keys_n = 3'b111;
  logic [2:0] pressed, press_pulse, release_pulse, repeat_pulse;
  logic       tick;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcnt = 0;
  ev_t  exp_q[$];

  key_conditioner #(
    .NUM_KEYS(3), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(8),
    .REPEAT_TICKS(2), .REPEAT_MASK(3'b010)
  ) dut (
    .clk(clk), .reset(reset), .keys_n(keys_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .tick(tick)
  );

  always #5 clk = ~clk;

  // Cycle counter plus the prescaler as specified (0 on reset, wraps after 3).
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    mcnt <= !reset ? 0 : ((mcnt == 3) ? 0 : mcnt + 1);
  end

  always @(negedge clk) begin
    for (int kind = 0; kind < 3; kind++) begin
      for (int k = 0; k < 3; k++) begin
        logic b;
        ev_t  e;
        b = (kind == KP) ? press_pulse[k] : (kind == KR) ? release_pulse[k] : repeat_pulse[k];
        if (b === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got kind=%0d key=%0d at cycle %0d, expected none",
                     kind, k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.key !== k || e.cyc !== cyc) begin
              errors++;
              $display("FAIL pulse_event: got kind=%0d key=%0d cyc=%0d, expected kind=%0d key=%0d cyc=%0d",
                       kind, k, cyc, e.kind, e.key, e.cyc);
            end
          end
        end
      end
    end
  end

  function automatic void push(int kind, int key, int c);
    ev_t e;
    e.kind = kind; e.key = key; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic step_to(int c);
    while (cyc < c) step();
  endtask

  // Land in the cycle right after a tick, so the next tick is 3 cycles away.
  task automatic align();
    step();
    while (mcnt != 0) step();
  endtask

  task automatic end_check(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: %0d expected events never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (pressed !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle_pressed: got %b, expected 000", name, pressed);
    end
  endtask

  task automatic test_reset();
    int c0, c1;
    reset = 1'b0; keys_n = 3'b000;
    repeat (10) step();
    checks++;
    if ({pressed, press_pulse, release_pulse, repeat_pulse, tick} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {pressed, press_pulse, release_pulse, repeat_pulse, tick});
    end
    reset = 1'b1; c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tick !== (i == 3)) begin
        errors++;
        $display("FAIL reset_first_tick: cycle %0d after release tick=%b, expected %b", i + 1, tick, i == 3);
      end
      if (i < 3) step();
    end
    for (int k = 0; k < 3; k++) push(KP, k, c0 + 12);
    step_to(c0 + 13);
    checks++;
    if (pressed !== 3'b111) begin
      errors++;
      $display("FAIL reset_pressed_all: got %b, expected 111", pressed);
    end
    align(); c1 = cyc;
    keys_n = 3'b111;
    for (int k = 0; k < 3; k++) push(KR, k, c1 + 12);
    step_to(c1 + 16);
    end_check("reset");
  endtask

  task automatic test_clean_press();
    int c0;
    align(); c0 = cyc;
    keys_n = 3'b110;
    push(KP, 0, c0 + 12);
    step_to(c0 + 60);
    checks++;
    if (pressed !== 3'b001) begin
      errors++;
      $display("FAIL clean_pressed: got %b, expected 001", pressed);
    end
    keys_n = 3'b111;
    push(KR, 0, c0 + 72);
    step_to(c0 + 76);
    end_check("clean");
  endtask

  task automatic test_bounce();
    align();
    for (int r = 0; r < 5; r++) begin
      keys_n = 3'b110;
      repeat (8) step();
      checks++;
      if (pressed[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_pressed: round %0d got %b, expected 0", r, pressed[0]);
      end
      keys_n = 3'b111;
      repeat (8) step();
    end
    end_check("bounce");
  endtask

  task automatic test_repeat();
    int c0;
    align(); c0 = cyc;
    keys_n = 3'b101;
    push(KP, 1, c0 + 12);
    push(KT, 1, c0 + 44);
    push(KT, 1, c0 + 52);
    push(KT, 1, c0 + 60);
    step_to(c0 + 30);
    checks++;
    if (pressed !== 3'b010) begin
      errors++;
      $display("FAIL repeat_pressed: got %b, expected 010", pressed);
    end
    step_to(c0 + 60);
    keys_n = 3'b111;
    push(KR, 1, c0 + 72);
    step_to(c0 + 76);
    end_check("repeat");
  endtask

  task automatic test_release_glitch();
    int c0;
    logic dropped;
    align(); c0 = cyc;
    keys_n = 3'b110;
    push(KP, 0, c0 + 12);
    step_to(c0 + 20);
    keys_n = 3'b111;
    dropped = 1'b0;
    while (cyc < c0 + 24) begin
      if (pressed[0] !== 1'b1) dropped = 1'b1;
      step();
    end
    keys_n = 3'b110;
    while (cyc < c0 + 40) begin
      if (pressed[0] !== 1'b1) dropped = 1'b1;
      step();
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pressed_held: pressed[0] dropped=%b, expected 0", dropped);
    end
    keys_n = 3'b111;
    push(KR, 0, c0 + 52);
    step_to(c0 + 56);
    end_check("glitch");
  endtask

  task automatic test_reset_mid_hold();
    int c0, c2;
    align(); c0 = cyc;
    keys_n = 3'b101;
    push(KP, 1, c0 + 12);
    push(KT, 1, c0 + 44);
    step_to(c0 + 46);
    reset = 1'b0;
    step();
    checks++;
    if ({pressed, press_pulse, release_pulse, repeat_pulse, tick} !== 13'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b, expected all zero",
               {pressed, press_pulse, release_pulse, repeat_pulse, tick});
    end
    reset = 1'b1; c2 = cyc;
    push(KP, 1, c2 + 12);
    step_to(c2 + 20);
    checks++;
    if (pressed !== 3'b010) begin
      errors++;
      $display("FAIL midreset_repressed: got %b, expected 010", pressed);
    end
    keys_n = 3'b111;
    push(KR, 1, c2 + 32);
    step_to(c2 + 36);
    end_check("midreset");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
